// File: rtl/mem_dump_reader_if.sv
// Stream/memory bundle for mem_dump_reader.
// The slave modport is the reader's view. The master modport is the view of
// whatever drives the reader: the memory model, the sink and the start logic.
// MEM_DUMP_CHECKSUM_EN adds the Checksum signal.
interface mem_dump_reader_if #(
  parameter int ADDR_W = 9
);
  logic              Start;
  logic [ADDR_W-1:0] Start_Addr;
  logic [ADDR_W-1:0] End_Addr;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Rd;
  logic [7:0]        Mem_Data;
  logic [31:0]       Word_out;
  logic [ADDR_W-1:0] Word_Addr;
  logic              Word_Valid;
  logic              Word_Ready;
  logic              Busy;
  logic              Done;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0]       Checksum;
`endif

  modport slave (
    input  Start, Start_Addr, End_Addr, Mem_Data, Word_Ready,
`ifdef MEM_DUMP_CHECKSUM_EN
    output Checksum,
`endif
    output Mem_Addr, Mem_Rd, Word_out, Word_Addr, Word_Valid, Busy, Done
  );

  modport master (
    output Start, Start_Addr, End_Addr, Mem_Data, Word_Ready,
`ifdef MEM_DUMP_CHECKSUM_EN
    input  Checksum,
`endif
    input  Mem_Addr, Mem_Rd, Word_out, Word_Addr, Word_Valid, Busy, Done
  );
endinterface

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks an inclusive, word-aligned byte window of a
// byte-wide memory. It assembles each group of four bytes big-endian and
// offers the word with its address on a valid/ready stream.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN adds a running 32-bit sum of
// every accepted word.
//
// state | meaning
// IDLE  | waiting for Start; window bounds latched on Start
// FETCH | four read cycles, byte counter k = 0..3, Mem_Addr = ptr + k
// CAPT  | last byte arrives; word and address loaded into the output regs
// SEND  | Word_Valid high until the sink accepts
// DONE  | one-cycle Done pulse, then back to IDLE
module mem_dump_reader #(
  parameter int ADDR_W = 9
) (
  input  logic              Clk,
  input  logic              Clr,
  mem_dump_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] end_q;
  logic [1:0]        k_q;
  logic [23:0]       asm_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] waddr_q;

  logic [ADDR_W-1:0] start_al;
  logic [ADDR_W-1:0] end_al;
  logic              handshake;
  logic              last_word;

  assign start_al  = bus.Start_Addr & ALIGN_MASK;
  assign end_al    = bus.End_Addr & ALIGN_MASK;
  assign handshake = (state_q == SEND) && bus.Word_Ready;
  // Compare before incrementing, so a window that ends at the top word stops without wrapping.
  assign last_word = (ptr_q == end_q);

  // State register.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = (end_al < start_al) ? DONE : FETCH;
      FETCH:   if (k_q == 2'd3) state_d = CAPT;
      CAPT:    state_d = SEND;
      SEND:    if (bus.Word_Ready) state_d = last_word ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window pointer, byte counter, byte assembly and the output word registers.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      ptr_q   <= '0;
      end_q   <= '0;
      k_q     <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            ptr_q <= start_al;
            end_q <= end_al;
            k_q   <= '0;
          end
        end
        FETCH: begin
          k_q <= k_q + 2'd1;
          // The byte on Mem_Data belongs to the previous read (k-1).
          if (k_q != 2'd0) asm_q <= {asm_q[15:0], bus.Mem_Data};
        end
        CAPT: begin
          word_q  <= {asm_q, bus.Mem_Data};
          waddr_q <= ptr_q;
        end
        SEND: begin
          if (bus.Word_Ready && !last_word) ptr_q <= ptr_q + WORD_STEP;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running sum of accepted words. It is cleared on an accepted Start.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)                              csum_q <= '0;
    else if (state_q == IDLE && bus.Start) csum_q <= '0;
    else if (handshake)                    csum_q <= csum_q + word_q;
  end

  assign bus.Checksum = csum_q;
`endif

  // Outputs are decoded from state, so an async reset clears them at once.
  assign bus.Mem_Rd     = (state_q == FETCH);
  assign bus.Mem_Addr   = (state_q == FETCH) ? (ptr_q + ADDR_W'(k_q)) : '0;
  assign bus.Word_Valid = (state_q == SEND);
  assign bus.Word_out   = word_q;
  assign bus.Word_Addr  = waddr_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.Done       = (state_q == DONE);

endmodule
